// File: rtl/sat_engine_ctrl_if.sv
// Handshake bundle between the Sat Engine phase sequencer and one bin's
// var state array plus its host. The master side is the sequencer.
interface sat_engine_ctrl_if #(
    parameter int WIDTH_LVL = 16,
    parameter int WIDTH_CNT = 16
);
    // Host control
    logic                 start_i;
    logic                 abort_i;
    logic                 load_req_i;
    logic                 load_done_i;
    // OR/max-reduced flags from the var state array
    logic                 all_assigned_i;
    logic                 find_imply_i;
    logic                 find_conflict_i;
    logic [WIDTH_LVL-1:0] max_lvl_i;
    // Strobes and levels towards the array
    logic                 wr_states_o;
    logic                 valid_from_decision_o;
    logic                 apply_imply_o;
    logic                 apply_analyze_o;
    logic                 apply_bkt_o;
    logic [WIDTH_LVL-1:0] cur_lvl_o;
    logic [WIDTH_LVL-1:0] bkt_lvl_o;
    // Result and status
    logic                 busy_o;
    logic                 done_o;
    logic                 sat_o;
    logic                 unsat_o;
    logic                 err_o;
    logic [WIDTH_CNT-1:0] conflict_cnt_o;

    modport master (
        input  start_i, abort_i, load_req_i, load_done_i,
               all_assigned_i, find_imply_i, find_conflict_i, max_lvl_i,
        output wr_states_o, valid_from_decision_o, apply_imply_o,
               apply_analyze_o, apply_bkt_o, cur_lvl_o, bkt_lvl_o,
               busy_o, done_o, sat_o, unsat_o, err_o, conflict_cnt_o
    );

    modport slave (
        output start_i, abort_i, load_req_i, load_done_i,
               all_assigned_i, find_imply_i, find_conflict_i, max_lvl_i,
        input  wr_states_o, valid_from_decision_o, apply_imply_o,
               apply_analyze_o, apply_bkt_o, cur_lvl_o, bkt_lvl_o,
               busy_o, done_o, sat_o, unsat_o, err_o, conflict_cnt_o
    );
endinterface

// File: rtl/sat_engine_ctrl.sv
// Phase sequencer for one Sat Engine bin: load, imply, decide, conflict
// analysis and backtrack, with decision-level tracking and SAT/UNSAT/error
// reporting. All outputs are registered.
module sat_engine_ctrl #(
    parameter int WIDTH_LVL      = 16,
    parameter int ANALYZE_CYCLES = 2,
    parameter int WIDTH_CNT      = 16,
    parameter int MAX_IMPLY_ITER = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sat_engine_ctrl_if.master bus
);
    localparam int                   ACW        = (ANALYZE_CYCLES > 1) ? $clog2(ANALYZE_CYCLES) : 1;
    localparam logic [ACW-1:0]       ANA_LAST   = ACW'(ANALYZE_CYCLES - 1);
    localparam logic [WIDTH_CNT-1:0] ITER_LIMIT = WIDTH_CNT'(MAX_IMPLY_ITER);
    localparam logic [WIDTH_CNT-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH_LVL-1:0] LVL_MAX    = '1;
    localparam logic [WIDTH_LVL-1:0] LVL_ONE    = WIDTH_LVL'(1);
    localparam logic [WIDTH_CNT-1:0] CNT_ONE    = WIDTH_CNT'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DECIDE, S_IMPLY, S_IMPLY_CHK, S_ANALYZE, S_BKT, S_DONE
    } state_e;

    state_e               state;
    logic                 wr_states, valid_dec, apply_imply, apply_analyze, apply_bkt;
    logic [WIDTH_LVL-1:0] cur_lvl, bkt_lvl, bkt_target;
    logic                 busy, done, sat, unsat, err;
    logic [WIDTH_CNT-1:0] iter_cnt, conflict_cnt;
    logic [ACW-1:0]       ana_cnt;

    // Backtrack target: deepest level reported by the array, kept strictly below cur_lvl
    always_comb begin
        // NOTE: give every combinational output a default first so no latch is inferred.
        bkt_target = bus.max_lvl_i;
        if (bus.max_lvl_i >= cur_lvl) bkt_target = cur_lvl - LVL_ONE;
    end

    // Phase sequencer with registered strobes, levels, counters and results
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            state         <= S_IDLE;
            wr_states     <= 1'b0;
            valid_dec     <= 1'b0;
            apply_imply   <= 1'b0;
            apply_analyze <= 1'b0;
            apply_bkt     <= 1'b0;
            cur_lvl       <= '0;
            bkt_lvl       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sat           <= 1'b0;
            unsat         <= 1'b0;
            err           <= 1'b0;
            iter_cnt      <= '0;
            conflict_cnt  <= '0;
            ana_cnt       <= '0;
        end else if (bus.abort_i && state != S_IDLE) begin
            // Abort wins over everything; the decision level is kept for inspection
            state         <= S_IDLE;
            wr_states     <= 1'b0;
            valid_dec     <= 1'b0;
            apply_imply   <= 1'b0;
            apply_analyze <= 1'b0;
            apply_bkt     <= 1'b0;
            busy          <= 1'b0;
            {done, sat, unsat, err} <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-arms them below
            wr_states     <= 1'b0;
            valid_dec     <= 1'b0;
            apply_imply   <= 1'b0;
            apply_analyze <= 1'b0;
            apply_bkt     <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.load_req_i) begin
                        state     <= S_LOAD;
                        wr_states <= 1'b1;
                        busy      <= 1'b1;
                        {done, sat, unsat, err} <= '0;
                    end else if (bus.start_i) begin
                        state        <= S_IMPLY;
                        apply_imply  <= 1'b1;
                        busy         <= 1'b1;
                        cur_lvl      <= '0;
                        iter_cnt     <= '0;
                        conflict_cnt <= '0;
                        {done, sat, unsat, err} <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.load_done_i) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wr_states <= 1'b1;
                    end
                end
                S_IMPLY: begin
                    // Entered from DECIDE the decision strobe occupies the first cycle
                    if (apply_imply) begin
                        state    <= S_IMPLY_CHK;
                        iter_cnt <= iter_cnt + CNT_ONE;
                    end else begin
                        apply_imply <= 1'b1;
                    end
                end
                S_IMPLY_CHK: begin
                    if (bus.find_conflict_i) begin
                        if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + CNT_ONE;
                        if (cur_lvl == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            unsat <= 1'b1;
                        end else begin
                            state         <= S_ANALYZE;
                            apply_analyze <= 1'b1;
                            ana_cnt       <= '0;
                        end
                    end else if (iter_cnt == ITER_LIMIT) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (bus.find_imply_i) begin
                        state       <= S_IMPLY;
                        apply_imply <= 1'b1;
                    end else begin
                        state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (bus.all_assigned_i) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sat   <= 1'b1;
                    end else if (cur_lvl == LVL_MAX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state     <= S_IMPLY;
                        cur_lvl   <= cur_lvl + LVL_ONE;
                        valid_dec <= 1'b1;
                        iter_cnt  <= '0;
                    end
                end
                S_ANALYZE: begin
                    if (ana_cnt == ANA_LAST) begin
                        state     <= S_BKT;
                        bkt_lvl   <= bkt_target;
                        apply_bkt <= 1'b1;
                    end else begin
                        ana_cnt       <= ana_cnt + ACW'(1);
                        apply_analyze <= 1'b1;
                    end
                end
                S_BKT: begin
                    state       <= S_IMPLY;
                    cur_lvl     <= bkt_lvl;
                    iter_cnt    <= '0;
                    apply_imply <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // At most one array strobe may be active in any cycle
    assert property (@(posedge clk) disable iff (!rst)
        $onehot0({wr_states, valid_dec, apply_imply, apply_analyze, apply_bkt}));

    assign bus.wr_states_o           = wr_states;
    assign bus.valid_from_decision_o = valid_dec;
    assign bus.apply_imply_o         = apply_imply;
    assign bus.apply_analyze_o       = apply_analyze;
    assign bus.apply_bkt_o           = apply_bkt;
    assign bus.cur_lvl_o             = cur_lvl;
    assign bus.bkt_lvl_o             = bkt_lvl;
    assign bus.busy_o                = busy;
    assign bus.done_o                = done;
    assign bus.sat_o                 = sat;
    assign bus.unsat_o               = unsat;
    assign bus.err_o                 = err;
    assign bus.conflict_cnt_o        = conflict_cnt;
endmodule
